// File: rtl/debug_wb_trace_queue.sv
`default_nettype none
// ============================================================================
// Module   : debug_wb_trace_queue
// Purpose  : Multi-lane writeback trace buffer that serialises retired records
//            onto a single-lane debug_wb_* trace port in program order.
// Revision : 1.0 - initial release
// ============================================================================
module debug_wb_trace_queue #(
    parameter int LANES      = 2,
    parameter int DEPTH      = 8,
    parameter bit SKIP_NOWEN = 1'b0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       w_stall,
    input  logic [LANES-1:0]           lane_valid,
    input  logic [LANES*32-1:0]        lane_pc,
    input  logic [LANES*4-1:0]         lane_wen,
    input  logic [LANES*5-1:0]         lane_wnum,
    input  logic [LANES*32-1:0]        lane_wdata,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem_pc    [DEPTH];
    logic [3:0]    r_mem_wen   [DEPTH];
    logic [4:0]    r_mem_wnum  [DEPTH];
    logic [31:0]   r_mem_wdata [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;

    logic             w_npop;
    logic [CW-1:0]    w_free;
    logic [CW-1:0]    w_npush;
    logic [CW-1:0]    w_nstored;
    logic [LANES-1:0] w_acc;
    logic [LANES-1:0] w_store;
    logic [CW-1:0]    w_off [LANES];
    logic [AW-1:0]    w_idx [LANES];

    assign full = (count > CW'(DEPTH - LANES));

    // Accepted lanes are packed into consecutive slots; a lane is kept only
    // while its compacted offset still fits in the space left after the pop.
    always_comb begin
        w_npop  = (count != '0);
        w_free  = CW'(DEPTH) - count + CW'(w_npop);
        w_npush = '0;
        w_acc   = '0;
        w_store = '0;
        for (int i = 0; i < LANES; i++) begin
            w_acc[i]   = lane_valid[i] && !w_stall &&
                         (!SKIP_NOWEN || (lane_wen[4*i +: 4] != 4'b0000));
            w_off[i]   = w_npush;
            w_idx[i]   = AW'({1'b0, r_tail} + w_npush);
            w_store[i] = w_acc[i] && (w_npush < w_free);
            if (w_acc[i]) begin
                w_npush = w_npush + CW'(1);
            end
        end
        w_nstored = (w_npush > w_free) ? w_free : w_npush;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_store[i]) begin
                r_mem_pc[w_idx[i]]    <= lane_pc[32*i +: 32];
                r_mem_wen[w_idx[i]]   <= lane_wen[4*i +: 4];
                r_mem_wnum[w_idx[i]]  <= lane_wnum[5*i +: 5];
                r_mem_wdata[w_idx[i]] <= lane_wdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head            <= '0;
            r_tail            <= '0;
            count             <= '0;
            overflow          <= 1'b0;
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            if (w_npop) begin
                debug_wb_pc       <= r_mem_pc[r_head];
                debug_wb_rf_wen   <= r_mem_wen[r_head];
                debug_wb_rf_wnum  <= r_mem_wnum[r_head];
                debug_wb_rf_wdata <= r_mem_wdata[r_head];
                r_head            <= r_head + AW'(1);
            end else begin
                debug_wb_pc       <= '0;
                debug_wb_rf_wen   <= '0;
                debug_wb_rf_wnum  <= '0;
                debug_wb_rf_wdata <= '0;
            end
            r_tail <= AW'(r_tail + AW'(w_nstored));
            count  <= count + w_nstored - CW'(w_npop);
            if (w_npush > w_free) begin
                overflow <= 1'b1;
            end
        end
    end

    // Offsets are consumed through w_idx; kept as an array for readability.
    logic w_unused;
    assign w_unused = ^w_off[0];

endmodule
`default_nettype wire

// File: tb/tb_debug_wb_trace_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_wb_trace_queue
// Purpose  : Scoreboard bench for debug_wb_trace_queue, SKIP_NOWEN=0 and =1
//            instances driven in parallel against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_wb_trace_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } rec_t;

    typedef struct {
        rec_t r;
        int   cnt;
        bit   full;
        bit   ovf;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b1;
    logic                  w_stall = 1'b0;
    logic [LANES-1:0]      lane_valid = '0;
    logic [LANES*32-1:0]   lane_pc = '0;
    logic [LANES*4-1:0]    lane_wen = '0;
    logic [LANES*5-1:0]    lane_wnum = '0;
    logic [LANES*32-1:0]   lane_wdata = '0;

    logic          full0, full1, ovf0, ovf1;
    logic [CW-1:0] count0, count1;
    logic [31:0]   pc0, pc1, wd0, wd1;
    logic [3:0]    wen0, wen1;
    logic [4:0]    wn0, wn1;

    int checks = 0;
    int errors = 0;

    rec_t mq0[$];
    rec_t mq1[$];
    bit   movf0, movf1;
    exp_t sb0[$];
    exp_t sb1[$];
    logic [31:0] next_pc = 32'h0000_1000;

    always #5 clk = ~clk;

    debug_wb_trace_queue #(.LANES(LANES), .DEPTH(DEPTH), .SKIP_NOWEN(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .w_stall(w_stall), .lane_valid(lane_valid),
        .lane_pc(lane_pc), .lane_wen(lane_wen), .lane_wnum(lane_wnum),
        .lane_wdata(lane_wdata), .full(full0), .count(count0), .overflow(ovf0),
        .debug_wb_pc(pc0), .debug_wb_rf_wen(wen0), .debug_wb_rf_wnum(wn0),
        .debug_wb_rf_wdata(wd0)
    );

    debug_wb_trace_queue #(.LANES(LANES), .DEPTH(DEPTH), .SKIP_NOWEN(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .w_stall(w_stall), .lane_valid(lane_valid),
        .lane_pc(lane_pc), .lane_wen(lane_wen), .lane_wnum(lane_wnum),
        .lane_wdata(lane_wdata), .full(full1), .count(count1), .overflow(ovf1),
        .debug_wb_pc(pc1), .debug_wb_rf_wen(wen1), .debug_wb_rf_wnum(wn1),
        .debug_wb_rf_wdata(wd1)
    );

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock edge of the reference: pop the oldest record first, then
    // append accepted lanes in order while the queue has room.
    task automatic model_step(input logic [LANES-1:0] v, input logic st,
                              input logic [LANES*32-1:0] pc, input logic [LANES*4-1:0] wen,
                              input logic [LANES*5-1:0] wn, input logic [LANES*32-1:0] wd);
        for (int k = 0; k < 2; k++) begin
            rec_t q[$];
            bit   ovf;
            exp_t e;
            rec_t r;
            if (k == 0) begin q = mq0; ovf = movf0; end
            else        begin q = mq1; ovf = movf1; end
            e.r = '0;
            if (q.size() > 0) e.r = q.pop_front();
            if (!st) begin
                for (int i = 0; i < LANES; i++) begin
                    if (v[i] && !(k == 1 && wen[4*i +: 4] == 4'h0)) begin
                        r.pc = pc[32*i +: 32]; r.wen = wen[4*i +: 4];
                        r.wnum = wn[5*i +: 5]; r.wdata = wd[32*i +: 32];
                        if (q.size() < DEPTH) q.push_back(r);
                        else ovf = 1'b1;
                    end
                end
            end
            e.cnt  = q.size();
            e.full = (q.size() > DEPTH - LANES);
            e.ovf  = ovf;
            if (k == 0) begin mq0 = q; movf0 = ovf; sb0.push_back(e); end
            else        begin mq1 = q; movf1 = ovf; sb1.push_back(e); end
        end
    endtask

    task automatic issue(input logic [LANES-1:0] v, input logic st,
                         input logic [LANES*32-1:0] pc, input logic [LANES*4-1:0] wen,
                         input logic [LANES*5-1:0] wn, input logic [LANES*32-1:0] wd);
        @(negedge clk);
        lane_valid = v; w_stall = st; lane_pc = pc;
        lane_wen = wen; lane_wnum = wn; lane_wdata = wd;
        model_step(v, st, pc, wen, wn, wd);
    endtask

    task automatic idle();
        issue('0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic issue_random(input bit honour_full, input bit force_both, input bit all_wen);
        logic [LANES-1:0]    v;
        logic [LANES*32-1:0] pc, wd;
        logic [LANES*4-1:0]  wen;
        logic [LANES*5-1:0]  wn;
        logic                st;
        v  = force_both ? '1 : LANES'($urandom);
        st = force_both ? 1'b0 :
             (($urandom_range(0, 9) == 0) || (honour_full && (mq0.size() > DEPTH - LANES)));
        for (int i = 0; i < LANES; i++) begin
            pc[32*i +: 32] = next_pc;
            if (v[i]) next_pc = next_pc + 32'd4;
            wen[4*i +: 4]  = (!all_wen && $urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wn[5*i +: 5]   = 5'($urandom);
            wd[32*i +: 32] = $urandom;
        end
        issue(v, st, pc, wen, wn, wd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_count0", 73'(count0), 73'(0));
        chk("rst_ovf0",   73'(ovf0),   73'(0));
        chk("rst_wen0",   73'(wen0),   73'(0));
        chk("rst_pc0",    73'(pc0),    73'(0));
        chk("rst_count1", 73'(count1), 73'(0));
        chk("rst_ovf1",   73'(ovf1),   73'(0));
        chk("rst_wen1",   73'(wen1),   73'(0));
        chk("rst_full0",  73'(full0),  73'(0));
        mq0.delete(); mq1.delete();
        movf0 = 1'b0; movf1 = 1'b0;
        lane_valid = '0; w_stall = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("trace0", {pc0, wen0, wn0, wd0}, 73'(e.r));
            chk("count0", 73'(count0), 73'(e.cnt));
            chk("full0",  73'(full0),  73'(e.full));
            chk("ovf0",   73'(ovf0),   73'(e.ovf));
        end
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("trace1", {pc1, wen1, wn1, wd1}, 73'(e.r));
            chk("count1", 73'(count1), 73'(e.cnt));
            chk("full1",  73'(full1),  73'(e.full));
            chk("ovf1",   73'(ovf1),   73'(e.ovf));
        end
    end

    initial begin
        do_reset();

        // Dual retire, single-lane compaction, and a no-write branch record.
        issue(2'b11, 1'b0, {32'hBFC0_0004, 32'hBFC0_0000}, 8'hFF, {5'd3, 5'd2},
              {32'h1111_2222, 32'h3333_4444});
        repeat (3) idle();
        issue(2'b10, 1'b0, {32'h0000_0100, 32'h0000_00FC}, 8'hF0, {5'd7, 5'd6},
              {32'hAAAA_0001, 32'h5555_0002});
        repeat (3) idle();
        issue(2'b11, 1'b0, {32'h0000_0204, 32'h0000_0200}, 8'hF0, {5'd8, 5'd1},
              {32'hCAFE_0008, 32'hDEAD_0001});
        repeat (3) idle();

        // Heavy traffic with full honoured: wraps pointers, must never overflow.
        repeat (200) issue_random(1'b1, 1'b0, 1'b0);
        repeat (DEPTH + 2) idle();

        // Ignore full: reaches 8 entries then drops, overflow stays sticky.
        repeat (9) issue_random(1'b0, 1'b1, 1'b1);
        repeat (20) issue_random(1'b1, 1'b0, 1'b0);
        repeat (DEPTH + 2) idle();

        // Four double pushes from empty leave five entries, then reset mid-stream.
        repeat (4) issue_random(1'b0, 1'b1, 1'b1);
        do_reset();
        repeat (40) issue_random(1'b1, 1'b0, 1'b0);
        repeat (DEPTH + 2) idle();

        @(posedge clk);
        #3;
        chk("sb_drained", 73'(sb0.size() + sb1.size()), 73'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
